// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM states,
// PC-mux select encodings and the PC width.
package pc_sequencer_pkg;

   localparam int PC_W = 32;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_SEQ  = 2'b00;
   localparam sel_t SEL_BR   = 2'b01;
   localparam sel_t SEL_ADDR = 2'b10;
   localparam sel_t SEL_JMP  = 2'b11;

endpackage

// File: rtl/pc_sequencer_pc_mux.sv
// 4-to-1 PC mux: picks the next fetch address from PC+4, jump target,
// register-jump address or branch target according to the 2-bit select.
module pc_sequencer_pc_mux
   import pc_sequencer_pkg::*;
(
   input  sel_t            sel,
   input  logic [PC_W-1:0] seq_pc,
   input  logic [PC_W-1:0] jmp_pc,
   input  logic [PC_W-1:0] addr_pc,
   input  logic [PC_W-1:0] br_pc,
   output logic [PC_W-1:0] next_pc
);

   // Select one of the four candidate addresses.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      next_pc = seq_pc;
      case (sel)
         SEL_JMP:  next_pc = jmp_pc;
         SEL_ADDR: next_pc = addr_pc;
         SEL_BR:   next_pc = br_pc;
         default:  next_pc = seq_pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: holds the fetch PC, arbitrates jump / jr / branch redirects
// (jump > jr > branch > sequential) and parks a redirect that cannot be taken
// yet in a one-entry pending register until the fetch can advance.
// Optional feature: define PC_EXC_VECTOR_EN to add an exception input that
// forces the PC to EXC_VECTOR (bypassing stall) and records the old PC in epc.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000
`ifdef PC_EXC_VECTOR_EN
   ,
   parameter logic [PC_W-1:0] EXC_VECTOR = 32'h8000_0180
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            jr,
   input  logic [PC_W-1:0] jr_target,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            stall,
   input  logic            if_ready,
`ifdef PC_EXC_VECTOR_EN
   input  logic            exc,
   output logic [PC_W-1:0] epc,
`endif
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            s1,
   output logic            s0,
   output logic [PC_W-1:0] next_pc
);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              pend_valid_q, pend_valid_d;
   sel_t              pend_sel_q, pend_sel_d;
   logic [PC_W-1:0]   pend_target_q, pend_target_d;
`ifdef PC_EXC_VECTOR_EN
   logic [PC_W-1:0]   epc_q, epc_d;
   logic              exc_act;
`endif

   logic              active;
   logic              new_req;
   logic              advance;
   sel_t              sel;
   logic [PC_W-1:0]   seq_pc;
   logic [PC_W-1:0]   jmp_in, addr_in, br_in;
   logic [PC_W-1:0]   mux_pc;

   assign active      = (state_q != BOOT);
   assign new_req     = active & (jump | jr | branch_taken);
   assign advance     = active & if_ready & ~stall;
   assign seq_pc      = pc_q + PC_W'(4);
   assign fetch_valid = active;
   assign pc          = pc_q;
   assign s1          = sel[1];
   assign s0          = sel[0];
`ifdef PC_EXC_VECTOR_EN
   assign exc_act     = active & exc;
   assign epc         = epc_q;
`endif

   // Arbitrate this cycle's select: fresh request by priority, else the pending redirect.
   always_comb begin
      sel     = SEL_SEQ;
      jmp_in  = jump_target;
      addr_in = jr_target;
      br_in   = branch_target;
      if (active) begin
         if (jump) begin
            sel = SEL_JMP;
         end else if (jr) begin
            sel = SEL_ADDR;
         end else if (branch_taken) begin
            sel = SEL_BR;
         end else if (pend_valid_q) begin
            sel     = pend_sel_q;
            jmp_in  = pend_target_q;
            addr_in = pend_target_q;
            br_in   = pend_target_q;
         end
      end
`ifdef PC_EXC_VECTOR_EN
      if (exc_act) begin
         sel = SEL_SEQ;
      end
`endif
   end

   pc_sequencer_pc_mux u_pc_mux (
      .sel     (sel),
      .seq_pc  (seq_pc),
      .jmp_pc  (jmp_in),
      .addr_pc (addr_in),
      .br_pc   (br_in),
      .next_pc (mux_pc)
   );

   // The exception vector overrides the mux output when enabled.
`ifdef PC_EXC_VECTOR_EN
   assign next_pc = exc_act ? EXC_VECTOR : mux_pc;
`else
   assign next_pc = mux_pc;
`endif

   // Next-state, PC update and pending-register management.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_sel_d    = pend_sel_q;
      pend_target_d = pend_target_q;
`ifdef PC_EXC_VECTOR_EN
      epc_d         = epc_q;
`endif
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN, HOLD: begin
            if (advance) begin
               pc_d         = next_pc;
               pend_valid_d = 1'b0;
               pend_sel_d   = SEL_SEQ;
               state_d      = RUN;
            end else if (new_req) begin
               pend_valid_d  = 1'b1;
               pend_sel_d    = sel;
               pend_target_d = mux_pc;
               state_d       = HOLD;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
`ifdef PC_EXC_VECTOR_EN
      if (exc_act) begin
         pc_d         = EXC_VECTOR;
         epc_d        = pc_q;
         pend_valid_d = 1'b0;
         pend_sel_d   = SEL_SEQ;
         state_d      = RUN;
      end
`endif
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the pending target is reset as well so a redirect cannot survive reset.
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_sel_q    <= SEL_SEQ;
         pend_target_q <= '0;
`ifdef PC_EXC_VECTOR_EN
         epc_q         <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_sel_q    <= pend_sel_d;
         pend_target_q <= pend_target_d;
`ifdef PC_EXC_VECTOR_EN
         epc_q         <= epc_d;
`endif
      end
   end

endmodule
